// File: rtl/ccip_flow_batch_tx_if.sv
// CCI-P channel-1 write request bundle (flattened header + payload).
// Ports: valid, req_type, vc_sel, cl_len, sop, address, data.
interface ccip_flow_batch_tx_if;
  logic         valid;
  logic [3:0]   req_type;
  logic [1:0]   vc_sel;
  logic [1:0]   cl_len;
  logic         sop;
  logic [41:0]  address;
  logic [511:0] data;

  modport master (
    output valid, req_type, vc_sel, cl_len, sop, address, data
  );
  modport slave (
    input valid, req_type, vc_sel, cl_len, sop, address, data
  );
endinterface

// File: rtl/ccip_flow_batch_tx.sv
// Multi-flow batched CCI-P c1 transmitter with per-flow flush timeout.
// Ports: clk, reset, flow/batch/timeout config, rpc_in push, sRx_c1TxAlmFull, sTx_c1, counters.
module ccip_flow_batch_tx #(
  parameter int DATA_WIDTH        = 512,
  parameter int LMAX_NUM_OF_FLOWS = 3,
  parameter int LFIFO_DEPTH       = 3,
  parameter int LMAX_BATCH        = 2,
  parameter int TIMEOUT_W         = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
  input  logic [41:0]                  tx_base_addr,
  input  logic [LMAX_BATCH-1:0]        l_tx_batch_size,
  input  logic [TIMEOUT_W-1:0]         flush_timeout,
  input  logic                         start,
  input  logic                         rpc_in_valid,
  input  logic [DATA_WIDTH-1:0]        rpc_in,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_in,
  input  logic                         sRx_c1TxAlmFull,
  ccip_flow_batch_tx_if.master         sTx_c1,
  output logic                         ccip_tx_ready,
  output logic [31:0]                  pdrop_cnt,
  output logic [31:0]                  flush_cnt
);
  localparam int NF    = 1 << LMAX_NUM_OF_FLOWS;
  localparam int DEPTH = 1 << LFIFO_DEPTH;
  localparam int PW    = LFIFO_DEPTH + 1;
  localparam int FW    = LMAX_NUM_OF_FLOWS;
  localparam logic [LMAX_BATCH-1:0] LB_MAX =
    LMAX_BATCH[LMAX_BATCH-1:0];

  typedef enum logic {SCAN, ISSUE} state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [NF][DEPTH];
  logic [PW-1:0] wptr [NF];
  logic [PW-1:0] rptr [NF];
  logic [PW-1:0] cnt [NF];
  logic [TIMEOUT_W-1:0] tmr [NF];

  logic [FW-1:0] p_q, p_d, nf_q;
  logic [LMAX_BATCH-1:0] lb_in, lb_q;
  logic [PW-1:0] bsz, cnt_p, n_q, beat_q;
  logic [41:0] base_q;
  logic flush_q;
  logic go, go_flush, pop;
  logic push_ok, drop, room;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [511:0] rd_wide;

  function automatic logic [FW-1:0] wrap(
    input logic [FW-1:0] p,
    input logic [FW-1:0] nf
  );
    return (p >= nf) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [1:0] clen(
    input logic [LMAX_BATCH-1:0] lb
  );
    return (lb == 0) ? 2'd0 : (lb == 1) ? 2'd1 : 2'd3;
  endfunction

  assign ccip_tx_ready = ~sRx_c1TxAlmFull;
  assign lb_in = (l_tx_batch_size > LB_MAX) ? LB_MAX : l_tx_batch_size;
  assign bsz   = PW'(1) << lb_in;

  always_comb begin
    for (int f = 0; f < NF; f++) cnt[f] = wptr[f] - rptr[f];
  end

  assign cnt_p   = cnt[p_q];
  assign rd_data = mem[p_q][rptr[p_q][LFIFO_DEPTH-1:0]];

  always_comb begin
    rd_wide = '0;
    rd_wide[DATA_WIDTH-1:0] = rd_data;
  end

  // A full FIFO still takes the push when it pops in the same cycle.
  assign room = (cnt[rpc_flow_id_in] != PW'(DEPTH)) ||
                (pop && p_q == rpc_flow_id_in);
  assign push_ok = start && rpc_in_valid && room;
  assign drop    = start && rpc_in_valid && !room;

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    go       = 1'b0;
    go_flush = 1'b0;
    pop      = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (!sRx_c1TxAlmFull) begin
          if (cnt_p >= bsz) begin
            go      = 1'b1;
            state_d = ISSUE;
          end else if (cnt_p != 0 && flush_timeout != 0 &&
                       tmr[p_q] >= flush_timeout) begin
            go       = 1'b1;
            go_flush = 1'b1;
            state_d  = ISSUE;
          end else begin
            p_d = wrap(p_q, number_of_flows);
          end
        end
      end
      ISSUE: begin
        pop = 1'b1;
        if (beat_q == n_q - 1'b1) begin
          state_d = SCAN;
          p_d     = wrap(p_q, nf_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[rpc_flow_id_in][wptr[rpc_flow_id_in][LFIFO_DEPTH-1:0]] <= rpc_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int f = 0; f < NF; f++) begin
        wptr[f] <= '0;
        rptr[f] <= '0;
        tmr[f]  <= '0;
      end
    end else begin
      for (int f = 0; f < NF; f++) begin
        logic pf, qf;
        pf = push_ok && rpc_flow_id_in == FW'(f);
        qf = pop && p_q == FW'(f);
        if (pf) wptr[f] <= wptr[f] + 1'b1;
        if (qf) rptr[f] <= rptr[f] + 1'b1;
        if (pf || qf) tmr[f] <= '0;
        else if (cnt[f] != 0 && !(state_q == ISSUE && p_q == FW'(f)) &&
                 tmr[f] != '1)
          tmr[f] <= tmr[f] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= SCAN;
      p_q              <= '0;
      nf_q             <= '0;
      lb_q             <= '0;
      n_q              <= '0;
      beat_q           <= '0;
      base_q           <= '0;
      flush_q          <= 1'b0;
      pdrop_cnt        <= '0;
      flush_cnt        <= '0;
      sTx_c1.valid     <= 1'b0;
      sTx_c1.req_type  <= '0;
      sTx_c1.vc_sel    <= '0;
      sTx_c1.cl_len    <= '0;
      sTx_c1.sop       <= 1'b0;
      sTx_c1.address   <= '0;
      sTx_c1.data      <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      if (go) begin
        n_q     <= go_flush ? cnt_p : bsz;
        flush_q <= go_flush;
        lb_q    <= lb_in;
        nf_q    <= number_of_flows;
        base_q  <= tx_base_addr;
        beat_q  <= '0;
        if (go_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
      end
      if (pop) beat_q <= beat_q + 1'b1;
      if (drop && pdrop_cnt != '1) pdrop_cnt <= pdrop_cnt + 32'd1;
      // Header is held at zero between requests.
      sTx_c1.valid    <= pop;
      sTx_c1.req_type <= 4'h0;
      sTx_c1.vc_sel   <= pop ? 2'd2 : 2'd0;
      sTx_c1.cl_len   <= (pop && !flush_q) ? clen(lb_q) : 2'd0;
      sTx_c1.sop      <= pop && (flush_q || beat_q == 0);
      sTx_c1.address  <= pop ? base_q + (42'(p_q) << lb_q) + 42'(beat_q) : '0;
      sTx_c1.data     <= pop ? rd_wide : '0;
    end
  end
endmodule

// File: tb/tb_ccip_flow_batch_tx.sv
// Randomized + directed bench for ccip_flow_batch_tx.
// Queue-based behavioural model, per-cycle compare, literal anchors.
module tb_ccip_flow_batch_tx;
  typedef logic [511:0] d_t;

  logic clk = 0;
  logic reset = 1;
  logic [2:0] number_of_flows = 0;
  logic [41:0] tx_base_addr = 0;
  logic [1:0] l_tx_batch_size = 0;
  logic [15:0] flush_timeout = 0;
  logic start = 1;
  logic rpc_in_valid = 0;
  d_t rpc_in = 0;
  logic [2:0] rpc_flow_id_in = 0;
  logic alm = 1;
  logic ccip_tx_ready;
  logic [31:0] pdrop_cnt, flush_cnt;

  ccip_flow_batch_tx_if c1 ();

  ccip_flow_batch_tx dut (
    .clk(clk),
    .reset(reset),
    .number_of_flows(number_of_flows),
    .tx_base_addr(tx_base_addr),
    .l_tx_batch_size(l_tx_batch_size),
    .flush_timeout(flush_timeout),
    .start(start),
    .rpc_in_valid(rpc_in_valid),
    .rpc_in(rpc_in),
    .rpc_flow_id_in(rpc_flow_id_in),
    .sRx_c1TxAlmFull(alm),
    .sTx_c1(c1),
    .ccip_tx_ready(ccip_tx_ready),
    .pdrop_cnt(pdrop_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;

  task automatic chk(string nm, d_t act, d_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: per-flow queues, idle timers, and a list of pending beats.
  d_t mq [8][$];
  int tmr_m [8];
  int rem, cur, beat, lbm, nfm, pm;
  bit fl;
  logic [41:0] basem;
  bit ev;
  logic [41:0] ea;
  logic [1:0] ecl;
  bit esop;
  d_t ed;
  int unsigned edrop, eflush;

  always @(posedge clk) begin : mdl
    int sz [8];
    bit popf [8];
    bit pushf [8];
    int lb, b, srv, f;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        mq[i].delete();
        tmr_m[i] = 0;
      end
      rem = 0; pm = 0; ev = 0; edrop = 0; eflush = 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        sz[i] = mq[i].size();
        popf[i] = 0;
        pushf[i] = 0;
      end
      ev = 0;
      srv = (rem > 0) ? cur : -1;
      if (rem > 0) begin
        ed = mq[cur].pop_front();
        popf[cur] = 1;
        ev = 1;
        ea = basem + (42'(cur) << lbm) + 42'(beat);
        ecl = fl ? 2'd0 : (lbm == 0 ? 2'd0 : lbm == 1 ? 2'd1 : 2'd3);
        esop = fl || beat == 0;
        beat++;
        rem--;
        if (rem == 0) pm = (cur >= nfm) ? 0 : cur + 1;
      end else if (!alm) begin
        lb = (l_tx_batch_size > 2) ? 2 : int'(l_tx_batch_size);
        b = 1 << lb;
        if (sz[pm] >= b || (sz[pm] > 0 && flush_timeout != 0 &&
                            tmr_m[pm] >= int'(flush_timeout))) begin
          fl = !(sz[pm] >= b);
          rem = fl ? sz[pm] : b;
          if (fl) eflush++;
          cur = pm; beat = 0; lbm = lb;
          nfm = int'(number_of_flows);
          basem = tx_base_addr;
        end else begin
          pm = (pm >= int'(number_of_flows)) ? 0 : pm + 1;
        end
      end
      if (start && rpc_in_valid) begin
        f = int'(rpc_flow_id_in);
        if (sz[f] < 8 || popf[f]) begin
          mq[f].push_back(rpc_in);
          pushf[f] = 1;
        end else edrop++;
      end
      for (int i = 0; i < 8; i++) begin
        if (pushf[i] || popf[i]) tmr_m[i] = 0;
        else if (sz[i] > 0 && srv != i && tmr_m[i] < 65535) tmr_m[i]++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid", d_t'(c1.valid), d_t'(ev));
      if (ev) begin
        chk("address", d_t'(c1.address), d_t'(ea));
        chk("cl_len", d_t'(c1.cl_len), d_t'(ecl));
        chk("sop", d_t'(c1.sop), d_t'(esop));
        chk("req_type", d_t'(c1.req_type), 0);
        chk("vc_sel", d_t'(c1.vc_sel), 2);
        chk("data", c1.data, ed);
      end
      chk("pdrop_cnt", d_t'(pdrop_cnt), d_t'(edrop));
      chk("flush_cnt", d_t'(flush_cnt), d_t'(eflush));
      chk("tx_ready", d_t'(ccip_tx_ready), d_t'(!alm));
    end
  end

  logic [41:0] obs_a [$];
  logic [1:0] obs_cl [$];
  logic obs_sop [$];

  always @(negedge clk) begin
    if (c1.valid === 1'b1) begin
      obs_a.push_back(c1.address);
      obs_cl.push_back(c1.cl_len);
      obs_sop.push_back(c1.sop);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_obs();
    obs_a.delete();
    obs_cl.delete();
    obs_sop.delete();
  endtask

  function automatic d_t rnd512();
    d_t d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic do_reset(logic a);
    alm = a;
    rpc_in_valid = 0;
    reset = 1;
    repeat (2) cyc();
    reset = 0;
    clr_obs();
  endtask

  task automatic push(int f);
    rpc_in_valid = 1;
    rpc_flow_id_in = 3'(f);
    rpc_in = rnd512();
    cyc();
    rpc_in_valid = 0;
  endtask

  task automatic wait_obs(string nm, int k, int budget);
    int t = 0;
    while (obs_a.size() < k && t < budget) begin
      cyc();
      t++;
    end
    chk(nm, d_t'(obs_a.size() >= k), 1);
  endtask

  initial begin
    logic [63:0] r64;
    cyc();
    reset = 1;
    repeat (2) cyc();
    chk("rst_valid", d_t'(c1.valid), 0);
    chk("rst_addr", d_t'(c1.address), 0);
    chk("rst_vc", d_t'(c1.vc_sel), 0);
    chk("rst_pdrop", d_t'(pdrop_cnt), 0);
    chk("rst_flush", d_t'(flush_cnt), 0);
    chk_on = 1;

    // T1
    tx_base_addr = 42'h100; l_tx_batch_size = 1;
    number_of_flows = 1; flush_timeout = 0;
    do_reset(0);
    push(1); push(1);
    wait_obs("t1_wait", 2, 20);
    chk("t1_a0", d_t'(obs_a[0]), 42'h102);
    chk("t1_a1", d_t'(obs_a[1]), 42'h103);
    chk("t1_cl", d_t'(obs_cl[1]), 1);
    chk("t1_sop0", d_t'(obs_sop[0]), 1);
    chk("t1_sop1", d_t'(obs_sop[1]), 0);

    // T2, base chosen so the second beat wraps past 2**42
    tx_base_addr = 42'h3FF_FFFF_FFFF; l_tx_batch_size = 2;
    number_of_flows = 0; flush_timeout = 8;
    do_reset(0);
    push(0); push(0); push(0);
    repeat (40) cyc();
    chk("t2_flush", d_t'(flush_cnt), 1);
    chk("t2_n", d_t'(obs_a.size()), 3);
    chk("t2_a0", d_t'(obs_a[0]), 42'h3FF_FFFF_FFFF);
    chk("t2_a1", d_t'(obs_a[1]), 0);
    chk("t2_a2", d_t'(obs_a[2]), 1);
    chk("t2_cl", d_t'(obs_cl[2]), 0);
    chk("t2_sop", d_t'(obs_sop[1]), 1);

    // T3
    tx_base_addr = 42'h100; l_tx_batch_size = 0;
    number_of_flows = 3; flush_timeout = 0;
    do_reset(1);
    repeat (10) push(2);
    chk("t3_pdrop", d_t'(pdrop_cnt), 2);
    alm = 0;
    wait_obs("t3_wait", 8, 200);
    repeat (10) cyc();
    chk("t3_n", d_t'(obs_a.size()), 8);
    chk("t3_a7", d_t'(obs_a[7]), 42'h102);

    // T4
    tx_base_addr = 0; l_tx_batch_size = 2;
    number_of_flows = 0; flush_timeout = 0;
    do_reset(0);
    repeat (4) push(0);
    wait_obs("t4_w1", 1, 20);
    alm = 1;
    repeat (4) push(0);
    repeat (20) cyc();
    chk("t4_hold", d_t'(obs_a.size()), 4);
    chk("t4_cl", d_t'(obs_cl[3]), 3);
    alm = 0;
    wait_obs("t4_w2", 8, 50);
    chk("t4_a4", d_t'(obs_a[4]), 0);
    chk("t4_sop4", d_t'(obs_sop[4]), 1);

    // T5
    tx_base_addr = 42'h40; l_tx_batch_size = 1;
    number_of_flows = 3; flush_timeout = 0;
    do_reset(1);
    push(3); push(3); push(0); push(0);
    alm = 0;
    wait_obs("t5_w1", 4, 50);
    chk("t5_a0", d_t'(obs_a[0]), 42'h40);
    chk("t5_a1", d_t'(obs_a[1]), 42'h41);
    chk("t5_a2", d_t'(obs_a[2]), 42'h46);
    chk("t5_a3", d_t'(obs_a[3]), 42'h47);
    push(0); push(0);
    wait_obs("t5_w2", 6, 50);
    chk("t5_a4", d_t'(obs_a[4]), 42'h40);

    // T6
    tx_base_addr = 0; l_tx_batch_size = 2;
    number_of_flows = 1; flush_timeout = 0;
    do_reset(0);
    repeat (4) push(1);
    wait_obs("t6_w", 2, 30);
    reset = 1;
    cyc();
    chk("t6_valid", d_t'(c1.valid), 0);
    chk("t6_pdrop", d_t'(pdrop_cnt), 0);
    reset = 0;
    repeat (20) cyc();
    chk("t6_n", d_t'(obs_a.size()), 2);
    l_tx_batch_size = 0;
    push(1);
    repeat (20) cyc();
    chk("t6_empty", d_t'(obs_a.size()), 3);

    // Random segments
    do_reset(0);
    for (int s = 0; s < 6; s++) begin
      l_tx_batch_size = 2'($urandom_range(0, 3));
      number_of_flows = 3'($urandom_range(0, 7));
      flush_timeout = ($urandom_range(0, 2) == 0) ? 16'd0 :
                      16'($urandom_range(2, 20));
      r64 = {$urandom, $urandom};
      tx_base_addr = r64[41:0];
      for (int c = 0; c < 800; c++) begin
        rpc_in_valid = ($urandom_range(0, 2) != 0);
        start = ($urandom_range(0, 15) != 0);
        rpc_flow_id_in = 3'($urandom_range(0, 7));
        rpc_in = rnd512();
        if ($urandom_range(0, 9) == 0) alm = ~alm;
        cyc();
      end
      rpc_in_valid = 0; start = 1; alm = 0;
      number_of_flows = 7; flush_timeout = 2;
      repeat (400) cyc();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
